masked_and_driver: RTL and testbench
====================================

MASKED_AND_DRIVER -- requirements
Module: masked_and_driver

Interface
REQ-001 The block SHALL have parameter D, default 3, giving the number of shares per operand; only D=3 is supported.
REQ-002 The block SHALL have parameter SEED, default 32'hACE1_2468, giving the PRNG reset value; it SHALL be nonzero.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port start, input, 1 bit: request one masked AND; sampled only in IDLE.
REQ-006 The block SHALL have ports a_in and b_in, input, 1 bit each: unmasked operands, sampled with start.
REQ-007 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-008 The block SHALL have port result, output, 1 bit: unmasked a_in AND b_in, held until the next capture.
REQ-009 The block SHALL have port result_valid, output, 1 bit: one-cycle pulse when result updates.
REQ-010 The block SHALL have port err, output, 1 bit: sticky timeout flag, cleared by the next accepted start.
REQ-011 The block SHALL have ports ina and inb, output, [0:D-1] each: operand shares to the gadget.
REQ-012 The block SHALL have port rin, output, [0:D*(D-1)/2-1]: fresh gadget randomness.
REQ-013 The block SHALL have port AndEnable, output, 1 bit: gadget enable.
REQ-014 The block SHALL have port AndDone, input, 1 bit: gadget done flag.
REQ-015 The block SHALL have port and_out, input, [0:D-1]: gadget output shares.

Function
REQ-016 The PRNG SHALL be a 32-bit Galois LFSR, polynomial x^32+x^22+x^2+x+1, advanced 8 steps every cycle, including while idle.
REQ-017 The FSM SHALL have states IDLE, LOAD, WAIT and DONE.
REQ-018 In IDLE, start=1 SHALL capture a_in/b_in, clear err and go to LOAD; start outside IDLE SHALL be ignored.
REQ-019 LOAD (one cycle) SHALL take r=lfsr[6:0] and register ina={a^r0^r1, r0, r1}, inb={b^r2^r3, r2, r3}, rin=r[6:4], assert AndEnable, and go to WAIT.
REQ-020 ina, inb, rin and AndEnable SHALL stay constant for the whole of WAIT.
REQ-021 WAIT SHALL count cycles, starting at 1 on the first WAIT cycle; the count saturates at 8.
REQ-022 AndDone SHALL be accepted only when count>=4; AndDone high at count<4 is stale or misaligned and SHALL be ignored.
REQ-023 On accepted AndDone, the block SHALL register result = and_out[0]^and_out[1]^and_out[2], pulse result_valid next cycle, drop AndEnable and go to DONE.
REQ-024 If count reaches 8 without acceptance, the block SHALL set err, leave result unchanged, give no result_valid pulse, drop AndEnable and go to DONE.
REQ-025 DONE (one cycle) SHALL drive ina/inb/rin to 0 and go to IDLE; the minimum start-to-start spacing is 7 cycles.
REQ-026 Latency from start to result_valid SHALL be 6 cycles for an aligned gadget and at most 8 for a misaligned one.
REQ-027 The block SHALL never expose unmasked operands on ina/inb; a_in/b_in are held only in internal registers, which are cleared in DONE.

Reset
REQ-028 On rst=1 the block SHALL set state=IDLE, lfsr=SEED, count=0 and all outputs to 0, including AndEnable, err, result and result_valid.
REQ-029 Reset mid-WAIT SHALL drop AndEnable on the following edge; the next operation relies on REQ-022 to tolerate gadget counter misalignment.
REQ-030 rst SHALL take priority over start in the same cycle.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding, the LFSR polynomial constant, WAIT_MIN=4 and WAIT_MAX=8.
REQ-032 The PRNG SHALL be a sub-module lfsr8_step (32-bit state, 8 steps/cycle, synchronous reset to SEED); the FSM stays in this module.

Verification
REQ-033 For all four (a,b) combinations with a behavioural gadget model, start SHALL produce result=a&b and a result_valid pulse 6 cycles after start.
REQ-034 With the gadget model held with AndDone=1 from the prior op, AndDone at count 1-3 SHALL be ignored, and result SHALL be correct at the true done.
REQ-035 With the gadget counter preloaded to 1 (misaligned), result_valid SHALL arrive 8 cycles after start with the correct result, and err SHALL stay 0.
REQ-036 With AndDone tied 0, err SHALL be 1 after 9 cycles, result_valid SHALL never fire, and the next start SHALL clear err.
REQ-037 Asserting rst in WAIT SHALL give AndEnable=0 and busy=0 next cycle and lfsr=SEED; a following op SHALL produce a correct result.
REQ-038 Over 10,000 ops, each share bit SHALL be 1 in 50%±2% of ops, and ina[0] SHALL never equal a in a fixed pattern.

Source files
------------

// File: rtl/masked_and_driver_pkg.sv
// Shared definitions for the masked AND driver: FSM encoding, PRNG constants
// and WAIT-window bounds.
package masked_and_driver_pkg;

  localparam int unsigned LFSR_W     = 32;
  localparam int unsigned LFSR_STEPS = 8;
  localparam int unsigned RND_W      = 7;
  localparam int unsigned CNT_W      = 4;

  // Galois taps for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [LFSR_W-1:0] LFSR_POLY = 32'h8020_0003;

  localparam logic [CNT_W-1:0] WAIT_MIN = CNT_W'(4);
  localparam logic [CNT_W-1:0] WAIT_MAX = CNT_W'(8);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_POLY) : (s >> 1);
  endfunction

endpackage

// File: rtl/masked_and_driver_lfsr8_step.sv
// Free-running 32-bit Galois LFSR advanced eight steps per clock; exposes the
// low bits as fresh masking randomness.
module lfsr8_step
  import masked_and_driver_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  output logic [RND_W-1:0] rnd
);

  logic [LFSR_W-1:0] state;
  logic [LFSR_W-1:0] state_d;

  always_comb begin
    state_d = state;
    for (int unsigned i = 0; i < LFSR_STEPS; i++) begin
      state_d = lfsr_step(state_d);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= SEED;
    end else begin
      state <= state_d;
    end
  end

  assign rnd = state[RND_W-1:0];

endmodule

// File: rtl/masked_and_driver.sv
// Drives a 3-share masked AND gadget: splits the operands into shares, waits
// for a plausibly-aligned done and unmasks the gadget output.
module masked_and_driver
  import masked_and_driver_pkg::*;
#(
  parameter int unsigned D    = 3,
  parameter logic [31:0] SEED = 32'hACE1_2468
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 a_in,
  input  logic                 b_in,
  output logic                 busy,
  output logic                 result,
  output logic                 result_valid,
  output logic                 err,
  output logic [0:D-1]         ina,
  output logic [0:D-1]         inb,
  output logic [0:D*(D-1)/2-1] rin,
  output logic                 AndEnable,
  input  logic                 AndDone,
  input  logic [0:D-1]         and_out
);

  localparam int unsigned R_W = D * (D - 1) / 2;

  state_e             state_q, state_d;
  logic               a_q, b_q, a_d, b_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [0:D-1]       ina_d, inb_d;
  logic [0:R_W-1]     rin_d;
  logic               en_d, result_d, valid_d, err_d, busy_d;
  logic [RND_W-1:0]   rnd;
  logic               accept_c, timeout_c;

  lfsr8_step #(.SEED(SEED)) u_prng (
    .clk (clk),
    .rst (rst),
    .rnd (rnd)
  );

  // Done seen before WAIT_MIN is stale or from a misaligned gadget counter
  assign accept_c  = (state_q == ST_WAIT) && AndDone && (count_q >= WAIT_MIN);
  assign timeout_c = (state_q == ST_WAIT) && !accept_c
                     && (count_q >= WAIT_MAX - CNT_W'(1));

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      a_q          <= 1'b0;
      b_q          <= 1'b0;
      count_q      <= '0;
      ina          <= '0;
      inb          <= '0;
      rin          <= '0;
      AndEnable    <= 1'b0;
      result       <= 1'b0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      a_q          <= a_d;
      b_q          <= b_d;
      count_q      <= count_d;
      ina          <= ina_d;
      inb          <= inb_d;
      rin          <= rin_d;
      AndEnable    <= en_d;
      result       <= result_d;
      result_valid <= valid_d;
      err          <= err_d;
      busy         <= busy_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_LOAD;
      ST_LOAD: state_d = ST_WAIT;
      ST_WAIT: if (accept_c || timeout_c) state_d = ST_DONE;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs and datapath
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    count_d  = count_q;
    ina_d    = ina;
    inb_d    = inb;
    rin_d    = rin;
    en_d     = AndEnable;
    result_d = result;
    valid_d  = 1'b0;
    err_d    = err;
    busy_d   = (state_d != ST_IDLE);
    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        if (start) begin
          a_d   = a_in;
          b_d   = b_in;
          err_d = 1'b0;
        end
      end
      ST_LOAD: begin
        ina_d   = {a_q ^ rnd[0] ^ rnd[1], rnd[0], rnd[1]};
        inb_d   = {b_q ^ rnd[2] ^ rnd[3], rnd[2], rnd[3]};
        rin_d   = rnd[6:4];
        en_d    = 1'b1;
        count_d = CNT_W'(1);
      end
      ST_WAIT: begin
        if (count_q < WAIT_MAX) count_d = count_q + CNT_W'(1);
        if (accept_c) begin
          result_d = ^and_out;
          valid_d  = 1'b1;
          en_d     = 1'b0;
        end else if (timeout_c) begin
          err_d = 1'b1;
          en_d  = 1'b0;
        end
      end
      ST_DONE: begin
        ina_d = '0;
        inb_d = '0;
        rin_d = '0;
        a_d   = 1'b0;
        b_d   = 1'b0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_masked_and_driver.sv
// Self-checking bench for masked_and_driver with a behavioural gadget model,
// an independent PRNG model and a result scoreboard.
module tb_masked_and_driver;

  localparam logic [31:0] TB_SEED = 32'hACE1_2468;
  localparam int          N_STAT  = 10000;

  logic       clk = 1'b0;
  logic       rst, start, a_in, b_in;
  logic       busy, result, result_valid, err, AndEnable, AndDone;
  logic [0:2] ina, inb, rin, and_out;

  int  n_vec  = 0;
  int  n_miss = 0;
  logic exp_q[$];

  // Gadget model controls
  logic [1:0] g_cnt;
  int         g_age;
  int         g_preload = 3;
  bit         g_stale_mode = 1'b0;
  bit         g_tie0 = 1'b0;
  logic       stale_c, g_a, g_b;

  logic [31:0] m_lfsr;
  int          ones [9];
  int          eq_a;

  masked_and_driver #(.D(3), .SEED(TB_SEED)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .a_in         (a_in),
    .b_in         (b_in),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid),
    .err          (err),
    .ina          (ina),
    .inb          (inb),
    .rin          (rin),
    .AndEnable    (AndEnable),
    .AndDone      (AndDone),
    .and_out      (and_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] tb_step8(input logic [31:0] s);
    logic [31:0] v;
    v = s;
    for (int k = 0; k < 8; k++) v = (v >> 1) ^ ({32{v[0]}} & 32'h8020_0003);
    return v;
  endfunction

  always @(posedge clk) begin
    if (rst) m_lfsr <= TB_SEED;
    else     m_lfsr <= tb_step8(m_lfsr);
  end

  // Gadget: down-counter reloaded while disabled, done when it reaches 0
  always @(posedge clk) begin
    if (AndEnable) g_cnt <= g_cnt - 2'd1;
    else           g_cnt <= 2'(g_preload);
    if (!AndEnable)     g_age <= 0;
    else if (g_age < 15) g_age <= g_age + 1;
  end

  // A stale done carries a corrupted output so an early accept shows up
  always_comb begin
    stale_c = g_stale_mode && (g_age < 3);
    g_a     = ^ina;
    g_b     = ^inb;
    and_out = {(g_a & g_b) ^ rin[0] ^ rin[1] ^ stale_c, rin[0] ^ rin[2], rin[1] ^ rin[2]};
  end
  assign AndDone = !g_tie0 && ((AndEnable && g_cnt == 2'd0) || stale_c);

  always @(negedge clk) begin
    if (!rst && result_valid) begin
      if (exp_q.size() == 0) begin
        check("rv_unexpected", 32'(result_valid), 32'd0);
      end else begin
        logic e;
        e = exp_q.pop_front();
        check("result", 32'(result), 32'(e));
      end
    end
  end

  // One operation; exp_vcyc/exp_ecyc are the cycle (start = cycle 0) at which
  // result_valid / err are first seen, 0 meaning never.
  task automatic run_op(input logic a, input logic b, input int exp_vcyc,
                        input int exp_ecyc, input bit hold);
    logic [31:0] r;
    logic [0:2]  ei, eb, er;
    int          cyc, vcyc, ecyc;
    a_in  = a;
    b_in  = b;
    start = 1'b1;
    @(posedge clk); #1;
    if (hold) begin
      a_in = ~a;
      b_in = ~b;
    end else begin
      start = 1'b0;
    end
    r    = m_lfsr;
    cyc  = 1;
    vcyc = 0;
    ecyc = 0;
    ei   = {a ^ r[0] ^ r[1], r[0], r[1]};
    eb   = {b ^ r[2] ^ r[3], r[2], r[3]};
    er   = r[6:4];
    if (exp_vcyc != 0) exp_q.push_back(a & b);
    check("busy_load", 32'(busy), 32'd1);
    check("err_cleared", 32'(err), 32'd0);
    while (busy && cyc < 16) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc == 3) start = 1'b0;
      if (result_valid && vcyc == 0) vcyc = cyc;
      if (err && ecyc == 0) ecyc = cyc;
      if (cyc == 2) begin
        check("ina", 32'(ina), 32'(ei));
        check("inb", 32'(inb), 32'(eb));
        check("rin", 32'(rin), 32'(er));
        check("and_en", 32'(AndEnable), 32'd1);
        for (int i = 0; i < 3; i++) begin
          ones[i]     += int'(ina[i]);
          ones[3 + i] += int'(inb[i]);
          ones[6 + i] += int'(rin[i]);
        end
        if (ina[0] == a) eq_a++;
      end
      if (cyc == 4) check("inputs_stable", 32'({ina, inb, rin, AndEnable}),
                          32'({ei, eb, er, 1'b1}));
    end
    check("op_ends", 32'(busy), 32'd0);
    check("valid_latency", 32'(vcyc), 32'(exp_vcyc));
    check("err_latency", 32'(ecyc), 32'(exp_ecyc));
    check("err_sticky", 32'(err), 32'(exp_ecyc != 0));
    check("shares_cleared", 32'({ina, inb, rin, AndEnable}), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic ra, rb;
    rst   = 1'b1;
    start = 1'b0;
    a_in  = 1'b0;
    b_in  = 1'b0;
    for (int i = 0; i < 9; i++) ones[i] = 0;
    eq_a = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_valid", 32'(result_valid), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_en", 32'(AndEnable), 32'd0);
    check("rst_shares", 32'({ina, inb, rin}), 32'd0);
    check("rst_lfsr", dut.u_prng.state, TB_SEED);
    rst = 1'b0;

    // All operand combinations with an aligned gadget
    for (int i = 0; i < 4; i++) run_op(1'(i >> 1), 1'(i), 6, 0, 1'b0);
    // start held high through LOAD and WAIT with flipped operands
    run_op(1'b1, 1'b1, 6, 0, 1'b1);

    // Stale done from the previous op during counts 1-3
    g_stale_mode = 1'b1;
    run_op(1'b1, 1'b1, 6, 0, 1'b0);
    run_op(1'b0, 1'b1, 6, 0, 1'b0);
    g_stale_mode = 1'b0;

    // Misaligned gadget counter
    g_preload = 1;
    run_op(1'b1, 1'b1, 8, 0, 1'b0);
    run_op(1'b1, 1'b0, 8, 0, 1'b0);
    g_preload = 3;

    // Gadget never finishes, then recovery
    g_tie0 = 1'b1;
    run_op(1'b1, 1'b1, 0, 9, 1'b0);
    g_tie0 = 1'b0;
    run_op(1'b1, 1'b1, 6, 0, 1'b0);

    // Reset in the middle of WAIT
    a_in  = 1'b1;
    b_in  = 1'b0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    check("wait_en", 32'(AndEnable), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_wait_en", 32'(AndEnable), 32'd0);
    check("rst_wait_busy", 32'(busy), 32'd0);
    check("rst_wait_lfsr", dut.u_prng.state, TB_SEED);
    rst = 1'b0;
    exp_q.delete();
    run_op(1'b1, 1'b1, 6, 0, 1'b0);

    // Share statistics over many random operations
    for (int i = 0; i < 9; i++) ones[i] = 0;
    eq_a = 0;
    for (int n = 0; n < N_STAT; n++) begin
      ra = 1'($urandom_range(0, 1));
      rb = 1'($urandom_range(0, 1));
      run_op(ra, rb, 6, 0, 1'b0);
    end
    for (int i = 0; i < 9; i++)
      check($sformatf("share_balance_%0d", i), 32'(ones[i] >= 4800 && ones[i] <= 5200), 32'd1);
    check("ina0_vs_a", 32'(eq_a >= 4800 && eq_a <= 5200), 32'd1);

    @(posedge clk); #1;
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
